// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encoding,
// default operand width and iteration-counter sizing.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, q} left,
// trial-subtract the divisor magnitude and keep the result when non-negative.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;

  // rem < dvsr keeps the trial within +/-2^WIDTH, so its MSB is a valid sign.
  always_comb begin
    rem_sh = {rem_i, q_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr_i};
    fits   = ~trial[WIDTH];
    rem_o  = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_o    = {q_i[WIDTH-2:0], fits};
  end

endmodule : div_step

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CNT_W = div_cnt_width(WIDTH);

  if (WIDTH < 2) begin : g_width_check
    $error("restoring_divider: WIDTH must be at least 2");
  end

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_rem, step_q;

  // Operand magnitudes and signs for the accepting edge.
  always_comb begin
`ifdef DIV_SIGNED_EN
    sign_a = dividend[WIDTH-1];
    sign_b = divisor[WIDTH-1];
    mag_a  = sign_a ? WIDTH'(-dividend) : dividend;
    mag_b  = sign_b ? WIDTH'(-divisor) : divisor;
`else
    sign_a = 1'b0;
    sign_b = 1'b0;
    mag_a  = dividend;
    mag_b  = divisor;
`endif
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .q_i    (q_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          neg_q_d = sign_a ^ sign_b;
          neg_r_d = sign_a;
          dvsr_d  = mag_b;
          if (divisor != '0) begin
            rem_d   = '0;
            q_d     = mag_a;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            quot_d  = '1;
            remo_d  = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        quot_d  = neg_q_q ? WIDTH'(-q_q) : q_q;
        remo_d  = neg_r_q ? WIDTH'(-rem_q) : rem_q;
        dz_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider against an arithmetic reference
// model; follows DIV_SIGNED_EN when it is defined.
module tb_restoring_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Reference: {div_zero, quotient, remainder} from plain integer division.
  function automatic logic [16:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    int ia, ib, iq, ir;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
`ifdef DIV_SIGNED_EN
    ia = $signed(a);
    ib = $signed(b);
`else
    ia = int'(a);
    ib = int'(b);
`endif
    iq = ia / ib;
    ir = ia % ib;
    return {1'b0, iq[7:0], ir[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for done; optional stray start pulse.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int glitch_at,
                        output logic [16:0] res, output int lat, output int bsy,
                        output logic ovl);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    bsy = 0;
    ovl = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      start = (lat == glitch_at);
      if (start) begin
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    ovl = busy & done;
    res = {div_zero, quotient, remainder};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    dividend = 8'd77;
    divisor = 8'd5;
    tick();
    tick();
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/dz=%b expected 000", {busy, done, div_zero});
    end
    n_tests++;
    if ({quotient, remainder} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got q=%h r=%h expected 00 00", quotient, remainder);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    logic [16:0] res;
    int lat, bsy;
    logic ovl;
    run_op(8'd100, 8'd7, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== {1'b0, 8'd14, 8'd2}) begin
      n_fail++;
      $display("FAIL basic_100_7: got dz/q/r=%h expected %h", res, {1'b0, 8'd14, 8'd2});
    end
    n_tests++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 9", lat);
    end
    n_tests++;
    if (bsy !== 9) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d expected 9", bsy);
    end
    n_tests++;
    if (ovl !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_done_overlap: got %b expected 0", ovl);
    end
  endtask

  task automatic test_div_zero();
    logic [16:0] res;
    int lat, bsy;
    logic ovl;
    run_op(8'd45, 8'd0, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== {1'b1, 8'hFF, 8'h2D}) begin
      n_fail++;
      $display("FAIL div_zero_result: got dz/q/r=%h expected %h", res, {1'b1, 8'hFF, 8'h2D});
    end
    n_tests++;
    if (lat !== 0 || bsy !== 0) begin
      n_fail++;
      $display("FAIL div_zero_timing: got lat=%0d busy=%0d expected 0 0", lat, bsy);
    end
  endtask

  task automatic test_sign_cases();
    logic [16:0] res;
    int lat, bsy;
    logic ovl;
`ifdef DIV_SIGNED_EN
    run_op(8'h9C, 8'd7, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== {1'b0, 8'hF2, 8'hFE}) begin
      n_fail++;
      $display("FAIL signed_m100_7: got %h expected %h", res, {1'b0, 8'hF2, 8'hFE});
    end
    run_op(8'h80, 8'hFF, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== {1'b0, 8'h80, 8'h00} || lat !== 9) begin
      n_fail++;
      $display("FAIL signed_overflow: got %h lat=%0d expected %h lat=9", res, lat,
               {1'b0, 8'h80, 8'h00});
    end
`else
    run_op(8'd200, 8'd3, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== {1'b0, 8'd66, 8'd2}) begin
      n_fail++;
      $display("FAIL unsigned_200_3: got %h expected %h", res, {1'b0, 8'd66, 8'd2});
    end
    run_op(8'hFF, 8'h01, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== {1'b0, 8'hFF, 8'h00}) begin
      n_fail++;
      $display("FAIL unsigned_255_1: got %h expected %h", res, {1'b0, 8'hFF, 8'h00});
    end
`endif
  endtask

  task automatic test_start_ignored();
    logic [16:0] res;
    int lat, bsy;
    logic ovl;
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom_range(1, 255));
    run_op(a, b, 2, res, lat, bsy, ovl);
    n_tests++;
    if (res !== ref_div(a, b) || lat !== 9) begin
      n_fail++;
      $display("FAIL start_ignored: got %h lat=%0d expected %h lat=9", res, lat, ref_div(a, b));
    end
  endtask

  task automatic test_rst_mid();
    logic [16:0] res;
    int lat, bsy;
    logic ovl;
    dividend = 8'd123;
    divisor = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    n_tests++;
    if ({busy, done, div_zero, quotient, remainder} !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got b/d/z/q/r=%b/%b/%b/%h/%h expected all 0",
               busy, done, div_zero, quotient, remainder);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got busy/done=%b expected 00", {busy, done});
    end
    run_op(8'd200, 8'd3, -1, res, lat, bsy, ovl);
    n_tests++;
    if (res !== ref_div(8'd200, 8'd3) || lat !== 9) begin
      n_fail++;
      $display("FAIL rst_mid_recover: got %h lat=%0d expected %h lat=9", res, lat,
               ref_div(8'd200, 8'd3));
    end
  endtask

  task automatic test_random();
    logic [16:0] res;
    int lat, bsy;
    logic ovl;
    logic [7:0] a, b;
    logic [7:0] special [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : 8'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 8'h00;
        1, 2:    b = special[$urandom_range(1, 5)];
        default: b = 8'($urandom);
      endcase
      run_op(a, b, -1, res, lat, bsy, ovl);
      n_tests++;
      if (res !== ref_div(a, b) || lat !== ((b == 8'd0) ? 0 : 9) || ovl !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h got %h lat=%0d ovl=%b expected %h", i, a, b, res,
                 lat, ovl, ref_div(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [6];
    logic [7:0] ob [6];
    int lat;
    for (int i = 0; i < 6; i++) begin
      oa[i] = 8'($urandom);
      ob[i] = 8'($urandom_range(1, 255));
    end
    dividend = oa[0];
    divisor = ob[0];
    start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        dividend = oa[k+1];
        divisor = ob[k+1];
      end else begin
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 8'($urandom);
      end
      lat = 0;
      while (!done && lat < 40) begin
        tick();
        lat++;
      end
      n_tests++;
      if ({div_zero, quotient, remainder} !== ref_div(oa[k], ob[k]) || lat !== 9) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h period=%0d expected %h period=10", k,
                 {div_zero, quotient, remainder}, lat + 1, ref_div(oa[k], ob[k]));
      end
      if (k < 5) begin
        tick();
        n_tests++;
        if ({busy, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_restart_%0d: got busy/done=%b expected 10", k, {busy, done});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_sign_cases();
    test_start_ignored();
    test_rst_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_restoring_divider
